mem_bus_arbiter: RTL and testbench

- Shares one unified SRAM bus between the IF-stage fetch port and the MEM-stage data port.
- Each bus transaction is sequenced with a req/ack handshake. The block returns fetched instructions and load data from holding registers.
- Raises pipeline stall requests until both outstanding accesses complete.
- Sits between the CPU core (MEM stage, IF stage, stall controller) and the external memory bus.

---
 rtl/mem_bus_arbiter_pkg.sv | 43 ++++
 rtl/mem_bus_arbiter_watchdog.sv | 37 +++
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared types and defaults for the IF/MEM unified bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================

package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_DATA  = 2'd1,
    ARB_INST  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_t;

  localparam logic [31:0] DEFAULT_ADDR_MASK      = 32'h1fff_ffff;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [3:0]  c_BE_WORD              = 4'hf;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
  } bus_cmd_t;

  function automatic bus_cmd_t make_cmd(input logic [31:0] addr,
                                        input logic [31:0] mask,
                                        input logic [3:0]  be,
                                        input logic        wr,
                                        input logic [31:0] wdata);
    bus_cmd_t cmd;
    cmd.addr  = addr & mask;
    cmd.be    = be;
    cmd.wr    = wr;
    cmd.wdata = wdata;
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_watchdog
// Description : Counts unacknowledged bus cycles and flags an expired request.
// Revision    : 1.0 - initial release
// ============================================================================

module mem_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ack,
  output logic o_expire
);

  localparam int c_NEED_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_CNT_W  = (c_NEED_W > 8) ? c_NEED_W : 8;
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;

  // Expires on the TIMEOUT_CYCLES-th consecutive cycle of an unanswered request
  assign o_expire = i_active & ~i_ack & (r_count == c_LIMIT);

  always_ff @(posedge clk) begin
    if (rst || !i_active || i_ack || o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one SRAM bus between IF fetches and MEM data accesses;
//               MEM_BUS_ARB_TIMEOUT_EN adds a request watchdog driving bus_err.
// Revision    : 1.0 - initial release
// ============================================================================

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK      = DEFAULT_ADDR_MASK,
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        ice,
  input  logic [31:0] iaddr,
  output logic [31:0] inst,
  input  logic        dce,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  input  logic [3:0]  dre,
  output logic [31:0] dm,
  input  logic        flush,
  output logic        stall_req_if,
  output logic        stall_req_mem,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic        bus_wr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  arb_state_t  r_state;
  bus_cmd_t    r_cmd;
  logic        r_bus_req;
  logic        r_d_done;
  logic        r_i_done;
  logic [31:0] r_inst;
  logic [31:0] r_dm;

  logic        w_d_pend;
  logic        w_i_pend;
  logic        w_advance;
  logic        w_timeout;
  logic        w_finish;
  logic        w_start_data;
  logic        w_start_inst;
  logic [31:0] w_result;
  bus_cmd_t    w_data_cmd;
  bus_cmd_t    w_inst_cmd;

  assign w_d_pend      = dce & ~r_d_done;
  assign w_i_pend      = ice & ~r_i_done;
  assign stall_req_mem = w_d_pend & ~flush;
  assign stall_req_if  = w_i_pend & ~flush;
  assign w_advance     = ~stall_req_mem & ~stall_req_if;

  assign w_data_cmd = make_cmd(daddr, ADDR_MASK, we | dre, |we, din);
  assign w_inst_cmd = make_cmd(iaddr, ADDR_MASK, c_BE_WORD, 1'b0, din);
  assign w_finish   = bus_ack | w_timeout;
  assign w_result   = w_timeout ? 32'h0 : bus_rdata;

  // Data wins in IDLE; a pending fetch chains onto the data ack with no gap
  always_comb begin
    w_start_data = 1'b0;
    w_start_inst = 1'b0;
    if (!flush) begin
      case (r_state)
        ARB_IDLE: begin
          w_start_data = w_d_pend;
          w_start_inst = ~w_d_pend & w_i_pend;
        end
        ARB_DATA: w_start_inst = bus_ack & w_i_pend;
        ARB_INST: w_start_data = bus_ack & w_d_pend;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_state   <= ARB_IDLE;
      r_bus_req <= 1'b0;
      r_cmd     <= '0;
      r_d_done  <= 1'b0;
      r_i_done  <= 1'b0;
      r_inst    <= 32'h0;
      r_dm      <= 32'h0;
    end else begin
      if (w_advance) begin
        r_d_done <= 1'b0;
        r_i_done <= 1'b0;
      end
      case (r_state)
        ARB_DATA, ARB_INST: begin
          if (w_finish) begin
            // A flush on the completing edge discards the result
            if (!flush) begin
              if (r_state == ARB_DATA) begin
                r_d_done <= 1'b1;
                if (!r_cmd.wr) r_dm <= w_result;
              end else begin
                r_i_done <= 1'b1;
                r_inst   <= w_result;
              end
            end
            r_state   <= ARB_IDLE;
            r_bus_req <= 1'b0;
          end else if (flush) begin
            r_state <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (w_finish) begin
            r_state   <= ARB_IDLE;
            r_bus_req <= 1'b0;
          end
        end
        default: ;
      endcase
      // A new issue overrides the return to IDLE above
      if (w_start_data) begin
        r_state   <= ARB_DATA;
        r_bus_req <= 1'b1;
        r_cmd     <= w_data_cmd;
      end else if (w_start_inst) begin
        r_state   <= ARB_INST;
        r_bus_req <= 1'b1;
        r_cmd     <= w_inst_cmd;
      end
    end
  end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  logic r_bus_err;

  mem_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (cpu_clk_50M),
    .rst      (cpu_rst),
    .i_active (r_bus_req),
    .i_ack    (bus_ack),
    .o_expire (w_timeout)
  );

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;
`endif

  assign inst      = r_inst;
  assign dm        = r_dm;
  assign bus_req   = r_bus_req;
  assign bus_addr  = r_cmd.addr;
  assign bus_be    = r_cmd.be;
  assign bus_wr    = r_cmd.wr;
  assign bus_wdata = r_cmd.wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Self-checking bench: transaction-level model plus bus responder.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_bus_arbiter;

  localparam logic [31:0] C_MASK = 32'h1fff_ffff;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
  } txn_t;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic        ice;
  logic [31:0] iaddr;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  we;
  logic [31:0] din;
  logic [3:0]  dre;
  logic        flush;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] inst;
  logic [31:0] dm;
  logic        stall_req_if;
  logic        stall_req_mem;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic        bus_wr;
  logic [31:0] bus_wdata;
  logic        bus_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wait_q[$];
  txn_t        obs_q[$];
  logic        use_fixed   = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  logic [31:0] exp_dm;
  logic [31:0] exp_inst;

  mem_bus_arbiter dut (
    .cpu_clk_50M   (cpu_clk_50M),
    .cpu_rst       (cpu_rst),
    .ice           (ice),
    .iaddr         (iaddr),
    .inst          (inst),
    .dce           (dce),
    .daddr         (daddr),
    .we            (we),
    .din           (din),
    .dre           (dre),
    .dm            (dm),
    .flush         (flush),
    .stall_req_if  (stall_req_if),
    .stall_req_mem (stall_req_mem),
    .bus_req       (bus_req),
    .bus_addr      (bus_addr),
    .bus_be        (bus_be),
    .bus_wr        (bus_wr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack),
    .bus_err       (bus_err)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h0bad_f00d;
  endfunction

  function automatic logic [31:0] tb_rdata(input logic [31:0] a);
    return use_fixed ? fixed_rdata : mem_word(a);
  endfunction

  // Memory side: logs each new transaction, holds it for its wait count, then acks
  initial begin : responder
    bit   busy;
    int   left;
    txn_t cur;
    txn_t now_cmd;
    busy      = 1'b0;
    left      = 0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge cpu_clk_50M);
      #1;
      bus_ack = 1'b0;
      now_cmd = {bus_addr, bus_be, bus_wr, bus_wdata};
      if (!bus_req) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          cur  = now_cmd;
          obs_q.push_back(now_cmd);
          left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end else begin
          check_eq("bus_stable_addr", now_cmd.addr, cur.addr);
          check_eq("bus_stable_ctl", {now_cmd.be, now_cmd.wr, now_cmd.wdata[26:0]},
                                     {cur.be, cur.wr, cur.wdata[26:0]});
        end
        if (left == 0) begin
          bus_ack   = 1'b1;
          bus_rdata = tb_rdata(bus_addr);
          busy      = 1'b0;
        end else begin
          left--;
        end
      end
    end
  end

  task automatic wait_idle(output int mem_c, output int if_c, output bit in_time);
    int n;
    mem_c   = 0;
    if_c    = 0;
    n       = 0;
    in_time = 1'b1;
    forever begin
      @(negedge cpu_clk_50M);
      if (!stall_req_mem && !stall_req_if) break;
      if (stall_req_mem) mem_c++;
      if (stall_req_if) if_c++;
      n++;
      if (n > 64) begin
        in_time = 1'b0;
        break;
      end
    end
  endtask

  // One pipeline step: present requests, wait for both stalls to release, compare
  task automatic run_step(input bit do_d, input bit do_i, input logic [31:0] da,
                          input logic [3:0] w, input logic [3:0] r, input logic [31:0] wd,
                          input logic [31:0] ia, input int wdat, input int winst);
    txn_t exp_q[$];
    int   mem_c;
    int   if_c;
    bit   in_time;
    obs_q.delete();
    if (do_d) begin
      exp_q.push_back({da & C_MASK, w | r, |w, wd});
      wait_q.push_back(wdat);
    end
    if (do_i) begin
      exp_q.push_back({ia & C_MASK, 4'hf, 1'b0, wd});
      wait_q.push_back(winst);
    end
    dce = do_d; daddr = da; we = w; dre = r; din = wd;
    ice = do_i; iaddr = ia;
    wait_idle(mem_c, if_c, in_time);
    check_eq("stall_release", {31'b0, in_time}, 32'd1);
    check_eq("stall_mem_cycles", mem_c, do_d ? 2 + wdat : 0);
    check_eq("stall_if_cycles", if_c, do_i ? (do_d ? 1 + wdat : 0) + 2 + winst : 0);
    if (do_d && w == 4'h0) exp_dm = tb_rdata(da & C_MASK);
    if (do_i) exp_inst = tb_rdata(ia & C_MASK);
    check_eq("dm", dm, exp_dm);
    check_eq("inst", inst, exp_inst);
    check_eq("txn_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      check_eq("txn_addr", obs_q[k].addr, exp_q[k].addr);
      check_eq("txn_be", 32'(obs_q[k].be), 32'(exp_q[k].be));
      check_eq("txn_wr", 32'(obs_q[k].wr), 32'(exp_q[k].wr));
      check_eq("txn_wdata", obs_q[k].wdata, exp_q[k].wdata);
    end
    @(posedge cpu_clk_50M);
    #1;
    dce = 1'b0; ice = 1'b0; we = 4'h0; dre = 4'h0;
  endtask

  initial begin : main
    int  mem_c;
    int  if_c;
    bit  in_time;
    cpu_rst = 1'b1; flush = 1'b0;
    ice = 1'b0; iaddr = 32'h0; dce = 1'b0; daddr = 32'h0;
    we = 4'h0; din = 32'h0; dre = 4'h0;
    exp_dm = 32'h0; exp_inst = 32'h0;

    repeat (2) @(posedge cpu_clk_50M);
    @(negedge cpu_clk_50M);
    check_eq("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'h0);
    check_eq("rst_bus_ctl", {27'b0, bus_be, bus_wr}, 32'h0);
    check_eq("rst_bus_wdata", bus_wdata, 32'h0);
    check_eq("rst_dm_inst", dm | inst, 32'h0);
    check_eq("rst_stalls", {30'b0, stall_req_mem, stall_req_if}, 32'h0);
    check_eq("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(posedge cpu_clk_50M);
    #1;
    cpu_rst = 1'b0;

    // Zero-wait load with a fixed read value
    use_fixed = 1'b1; fixed_rdata = 32'hdead_beef;
    run_step(1'b1, 1'b0, 32'h8000_0010, 4'h0, 4'hf, 32'h0, 32'h0, 0, 0);
    use_fixed = 1'b0;
    check_eq("load_dm_fixed", dm, 32'hdead_beef);

    // Simultaneous store + fetch, then a fetch with five wait states
    run_step(1'b1, 1'b1, 32'h0000_0040, 4'b0011, 4'h0, 32'h1234_1234, 32'hbfc0_0000, 0, 0);
    run_step(1'b0, 1'b1, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0000_0300, 0, 5);

    // Flush while a load is in flight; a fetch waits behind the drain
    obs_q.delete(); wait_q.delete();
    wait_q.push_back(6);
    wait_q.push_back(1);
    dce = 1'b1; dre = 4'hf; we = 4'h0; daddr = 32'h0000_0100;
    @(posedge cpu_clk_50M); #1;
    @(posedge cpu_clk_50M); #1;
    flush = 1'b1; ice = 1'b1; iaddr = 32'h0000_0200;
    @(negedge cpu_clk_50M);
    check_eq("flush_stalls", {30'b0, stall_req_mem, stall_req_if}, 32'h0);
    check_eq("flush_bus_req", {31'b0, bus_req}, 32'd1);
    @(posedge cpu_clk_50M); #1;
    flush = 1'b0; dce = 1'b0; dre = 4'h0;
    @(negedge cpu_clk_50M);
    check_eq("drain_stall_if", {31'b0, stall_req_if}, 32'd1);
    check_eq("drain_addr", bus_addr, 32'h0000_0100);
    wait_idle(mem_c, if_c, in_time);
    check_eq("drain_release", {31'b0, in_time}, 32'd1);
    exp_inst = mem_word(32'h0000_0200);
    check_eq("flush_dm_kept", dm, exp_dm);
    check_eq("flush_fetch_inst", inst, exp_inst);
    check_eq("flush_txn_count", obs_q.size(), 2);
    if (obs_q.size() == 2) check_eq("flush_fetch_addr", obs_q[1].addr, 32'h0000_0200);
    @(posedge cpu_clk_50M); #1;
    ice = 1'b0;

    // Reset while a load is waiting on the bus
    wait_q.delete();
    wait_q.push_back(10);
    dce = 1'b1; dre = 4'hf; daddr = 32'h0000_0500;
    @(posedge cpu_clk_50M); #1;
    @(posedge cpu_clk_50M); #1;
    check_eq("pre_rst_bus_req", {31'b0, bus_req}, 32'd1);
    cpu_rst = 1'b1; dce = 1'b0; dre = 4'h0;
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 1'b0;
    @(negedge cpu_clk_50M);
    exp_dm = 32'h0; exp_inst = 32'h0;
    check_eq("midrst_bus_req", {31'b0, bus_req}, 32'd0);
    check_eq("midrst_bus_addr", bus_addr, 32'h0);
    check_eq("midrst_bus_ctl", {27'b0, bus_be, bus_wr}, 32'h0);
    check_eq("midrst_dm", dm, exp_dm);
    check_eq("midrst_inst", inst, exp_inst);
    @(posedge cpu_clk_50M); #1;
    wait_q.delete(); obs_q.delete();

    for (int s = 0; s < 40; s++) begin
      bit         dd;
      bit         di;
      logic [3:0] wr_en;
      logic [3:0] rd_en;
      case ($urandom_range(0, 2))
        0:       begin dd = 1'b1; di = 1'b0; end
        1:       begin dd = 1'b0; di = 1'b1; end
        default: begin dd = 1'b1; di = 1'b1; end
      endcase
      if ($urandom_range(0, 1) == 1) begin
        wr_en = 4'($urandom_range(1, 15)); rd_en = 4'h0;
      end else begin
        wr_en = 4'h0; rd_en = 4'($urandom_range(1, 15));
      end
      run_step(dd, di, $urandom(), wr_en, rd_en, $urandom(), $urandom(),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(posedge cpu_clk_50M);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : global_limit
    #400000;
    $display("FAIL global_timeout: got no finish expected finish before limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
